// File: rtl/data_sram_resp_pkg.sv
// Shared types and constants for the latency-modelled data SRAM responder
// and the byte-merge helper it shares with the cache.
package data_sram_resp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [63:0] DEFAULT_BASE_ADDR = 64'h0000_0000_8000_0000;
  localparam int          BYTE_W            = 8;
  localparam int          WORD_W            = 64;
  localparam int          LANES             = WORD_W / BYTE_W;

  // Offset is the full 64-bit distance from the base, so anything below the
  // base wraps to a huge value and fails the check.
  function automatic logic addr_in_range(input logic [63:0] off,
                                         input logic [63:0] span);
    return (off < span);
  endfunction

endpackage

// File: rtl/data_sram_resp_byte_merge.sv
// Combinational byte-lane merge: lanes enabled in wmask take wdata, the rest
// keep the old word. Shared with the cache refill/store path.
module sram_byte_merge
  import data_sram_resp_pkg::*;
(
  input  logic [WORD_W-1:0] old_word,
  input  logic [WORD_W-1:0] wdata,
  input  logic [LANES-1:0]  wmask,
  output logic [WORD_W-1:0] merged
);

  // Per-lane select between old and new data.
  always_comb begin
    merged = old_word;
    for (int i = 0; i < LANES; i++) begin
      if (wmask[i]) begin
        merged[i*BYTE_W +: BYTE_W] = wdata[i*BYTE_W +: BYTE_W];
      end else begin
        merged[i*BYTE_W +: BYTE_W] = old_word[i*BYTE_W +: BYTE_W];
      end
    end
  end

endmodule

// File: rtl/data_sram_resp.sv
// Responder-side data memory: one outstanding read or byte-masked write,
// a counter-modelled access latency, and a valid/ready response channel.
module data_sram_resp
  import data_sram_resp_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter int          DEPTH     = 1024,
  parameter int          LATENCY   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [63:0]       req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  input  logic [LANES-1:0]  req_wmask,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int                IDX_W    = $clog2(DEPTH);
  localparam int                CNT_W    = $clog2(LATENCY + 1) + 1;
  localparam logic [CNT_W-1:0]  LAT_LOAD = CNT_W'(LATENCY);
  localparam logic [63:0]       SPAN     = 64'(DEPTH) * 64'd8;

  state_e             state_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               wen_r;
  logic [IDX_W-1:0]   idx_r;
  logic [WORD_W-1:0]  wdata_r;
  logic [LANES-1:0]   wmask_r;
  logic               inrange_r;

  logic [WORD_W-1:0]  mem [DEPTH];

  logic               accept_s;
  logic [63:0]        off_s;
  logic [IDX_W-1:0]   idx_s;
  logic               inrange_s;

  logic               commit_s;
  logic               c_wen_s;
  logic [IDX_W-1:0]   c_idx_s;
  logic [WORD_W-1:0]  c_wdata_s;
  logic [LANES-1:0]   c_wmask_s;
  logic               c_inrange_s;
  logic [WORD_W-1:0]  old_s;
  logic [WORD_W-1:0]  merged_s;
  logic [WORD_W-1:0]  rd_s;

  assign req_ready = (state_r == IDLE);
  assign accept_s  = req_valid && req_ready;
  assign off_s     = req_addr - BASE_ADDR;
  assign idx_s     = off_s[IDX_W+2:3];
  assign inrange_s = addr_in_range(off_s, SPAN);

  // With zero latency the commit edge is the acceptance edge, so the commit
  // works straight from the request inputs instead of the latched copy.
  always_comb begin
    commit_s    = 1'b0;
    c_wen_s     = wen_r;
    c_idx_s     = idx_r;
    c_wdata_s   = wdata_r;
    c_wmask_s   = wmask_r;
    c_inrange_s = inrange_r;
    if (LATENCY == 0) begin
      commit_s    = accept_s;
      c_wen_s     = req_wen;
      c_idx_s     = idx_s;
      c_wdata_s   = req_wdata;
      c_wmask_s   = req_wmask;
      c_inrange_s = inrange_s;
    end else begin
      commit_s    = (state_r == WAIT) && (cnt_r == CNT_W'(1));
    end
  end

  assign old_s = mem[c_idx_s];
  assign rd_s  = (!c_wen_s && c_inrange_s) ? old_s : {WORD_W{1'b0}};

  sram_byte_merge u_merge (
    .old_word (old_s),
    .wdata    (c_wdata_s),
    .wmask    (c_wmask_s),
    .merged   (merged_s)
  );

  // Storage update on the commit edge; the array itself is never reset.
  always_ff @(posedge clk) begin
    if (rst && commit_s && c_wen_s && c_inrange_s) begin
      mem[c_idx_s] <= merged_s;
    end
  end

  // Request/response FSM with registered response outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= IDLE;
      cnt_r     <= '0;
      wen_r     <= 1'b0;
      idx_r     <= '0;
      wdata_r   <= '0;
      wmask_r   <= '0;
      inrange_r <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            wen_r     <= req_wen;
            idx_r     <= idx_s;
            wdata_r   <= req_wdata;
            wmask_r   <= req_wmask;
            inrange_r <= inrange_s;
            cnt_r     <= LAT_LOAD;
            state_r   <= WAIT;
          end
        end
        WAIT: begin
          cnt_r <= cnt_r - CNT_W'(1);
        end
        RESP: begin
          if (rsp_ready) begin
            state_r   <= IDLE;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
      // The commit edge wins over the per-state updates above.
      if (commit_s) begin
        state_r   <= RESP;
        rsp_valid <= 1'b1;
        rsp_rdata <= rd_s;
        rsp_err   <= !c_inrange_s;
      end
    end
  end

endmodule

// File: tb/tb_data_sram_resp.sv
// Self-checking bench: directed vector table, hand-written corner sequences
// and randomized accesses against an associative-array memory model.
module tb_data_sram_resp;

  localparam logic [63:0] BASE  = 64'h0000_0000_8000_0000;
  localparam int          DEPTH = 1024;
  localparam int          LAT   = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst;
  logic        req_valid, req_ready, req_wen;
  logic [63:0] req_addr, req_wdata;
  logic [7:0]  req_wmask;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [63:0] rsp_rdata;

  logic        z_req_valid, z_req_ready, z_req_wen;
  logic [63:0] z_req_addr, z_req_wdata;
  logic [7:0]  z_req_wmask;
  logic        z_rsp_valid, z_rsp_err;
  logic [63:0] z_rsp_rdata;

  data_sram_resp #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  data_sram_resp #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .LATENCY(0)) dut0 (
    .clk(clk), .rst(rst),
    .req_valid(z_req_valid), .req_ready(z_req_ready), .req_wen(z_req_wen),
    .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_wmask(z_req_wmask),
    .rsp_valid(z_rsp_valid), .rsp_ready(1'b1),
    .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] model_mem [int];

  typedef struct {
    logic        wen;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    logic [63:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t tbl [13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: storage is a sparse map of word index -> 64-bit value.
  task automatic model_access(input logic wen, input logic [63:0] addr, input logic [63:0] wdata,
                              input logic [7:0] wmask, output logic [63:0] rdata, output logic err);
    logic [63:0] off;
    logic [63:0] w;
    int idx;
    off   = addr - BASE;
    err   = (off >= 64'(DEPTH) * 64'd8);
    rdata = 64'd0;
    if (!err) begin
      idx = int'(off / 64'd8);
      w   = model_mem.exists(idx) ? model_mem[idx] : 64'd0;
      if (wen) begin
        for (int b = 0; b < 8; b++)
          if (wmask[b]) w[b*8 +: 8] = wdata[b*8 +: 8];
        model_mem[idx] = w;
      end else begin
        rdata = w;
      end
    end
  endtask

  task automatic send_req(input logic wen, input logic [63:0] addr, input logic [63:0] wdata,
                          input logic [7:0] wmask);
    int n;
    n = 0;
    req_valid = 1'b1; req_wen = wen; req_addr = addr; req_wdata = wdata; req_wmask = wmask;
    while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
    check("accept_timeout", {63'd0, req_ready}, 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0; req_wen = 1'bx; req_addr = 'x; req_wdata = 'x; req_wmask = 'x;
  endtask

  // Counts edges after acceptance until rsp_valid is seen; expected LATENCY
  // (valid during the (LATENCY+1)th cycle counting the acceptance cycle).
  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!rsp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic finish_rsp(input int hold, output logic [63:0] rd, output logic er);
    rd = rsp_rdata; er = rsp_err;
    rsp_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check("hold_valid", {63'd0, rsp_valid}, 64'd1);
      check("hold_rdata", rsp_rdata, rd);
      check("hold_err", {63'd0, rsp_err}, {63'd0, er});
      check("hold_req_ready", {63'd0, req_ready}, 64'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("post_hs_valid", {63'd0, rsp_valid}, 64'd0);
    check("post_hs_rdata", rsp_rdata, 64'd0);
  endtask

  task automatic do_access(input string name, input logic wen, input logic [63:0] addr,
                           input logic [63:0] wdata, input logic [7:0] wmask, input int hold,
                           input logic [63:0] exp_rd, input logic exp_er);
    int lat;
    logic [63:0] rd;
    logic er;
    send_req(wen, addr, wdata, wmask);
    wait_rsp(lat);
    check({name, "_lat"}, 64'(lat), 64'(LAT));
    finish_rsp(hold, rd, er);
    check({name, "_rdata"}, rd, exp_rd);
    check({name, "_err"}, {63'd0, er}, {63'd0, exp_er});
  endtask

  logic [63:0] e_rd, rd2;
  logic        e_er, er2;
  int          lat2;

  initial begin
    rst = 1'b0; rsp_ready = 1'b0;
    req_valid = 1'b0; req_wen = 1'b0; req_addr = 64'd0; req_wdata = 64'd0; req_wmask = 8'd0;
    z_req_valid = 1'b0; z_req_wen = 1'b0; z_req_addr = 64'd0; z_req_wdata = 64'd0; z_req_wmask = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("rst_rsp_rdata", rsp_rdata, 64'd0);
    check("rst_rsp_err", {63'd0, rsp_err}, 64'd0);
    check("rst_req_ready", {63'd0, req_ready}, 64'd1);
    check("rst_z_rsp_valid", {63'd0, z_rsp_valid}, 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Zero-latency instance: back-to-back, rsp_ready tied high.
    begin
      logic [63:0] za [6];
      logic [63:0] zd [6];
      logic        zw [6];
      logic [63:0] ze [6];
      int last_acc, zn;
      za = '{64'h8000_0028, 64'h8000_0030, 64'h8000_0028, 64'h8000_0030, 64'h8000_002F, 64'h8000_0030};
      zd = '{64'h0BAD_F00D_1234_5678, 64'hFEED_FACE_9ABC_DEF0, 64'd0, 64'd0, 64'd0, 64'd0};
      zw = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      ze = '{64'd0, 64'd0, 64'h0BAD_F00D_1234_5678, 64'hFEED_FACE_9ABC_DEF0,
             64'h0BAD_F00D_1234_5678, 64'hFEED_FACE_9ABC_DEF0};
      last_acc = 0;
      for (int k = 0; k < 6; k++) begin
        z_req_valid = 1'b1; z_req_wen = zw[k]; z_req_addr = za[k];
        z_req_wdata = zd[k]; z_req_wmask = 8'hFF;
        zn = 0;
        while (!z_req_ready && zn < 10) begin @(posedge clk); #1; zn++; end
        check("l0_ready", {63'd0, z_req_ready}, 64'd1);
        @(posedge clk); #1;
        if (k > 0) check("l0_interval", 64'(cyc - last_acc), 64'd2);
        last_acc = cyc;
        check("l0_valid", {63'd0, z_rsp_valid}, 64'd1);
        check("l0_rdata", z_rsp_rdata, ze[k]);
        check("l0_err", {63'd0, z_rsp_err}, 64'd0);
        @(posedge clk); #1;
        check("l0_done", {63'd0, z_rsp_valid}, 64'd0);
      end
      z_req_valid = 1'b0;
    end

    // Directed vector table.
    tbl[0]  = '{1'b1, 64'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF, 64'd0, 1'b0};
    tbl[1]  = '{1'b0, 64'h8000_0010, 64'd0, 8'h00, 64'h1122_3344_5566_7788, 1'b0};
    tbl[2]  = '{1'b1, 64'h8000_0010, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F, 64'd0, 1'b0};
    tbl[3]  = '{1'b0, 64'h8000_0010, 64'd0, 8'h00, 64'h1122_3344_AAAA_AAAA, 1'b0};
    tbl[4]  = '{1'b1, 64'h8000_0000, 64'h0123_4567_89AB_CDEF, 8'hFF, 64'd0, 1'b0};
    tbl[5]  = '{1'b0, 64'h7FFF_FFF8, 64'd0, 8'h00, 64'd0, 1'b1};
    tbl[6]  = '{1'b1, 64'h8000_2000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 64'd0, 1'b1};
    tbl[7]  = '{1'b0, 64'h8000_0000, 64'd0, 8'h00, 64'h0123_4567_89AB_CDEF, 1'b0};
    tbl[8]  = '{1'b1, 64'h8000_0017, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 64'd0, 1'b0};
    tbl[9]  = '{1'b0, 64'h8000_0015, 64'd0, 8'h00, 64'h1122_3344_AAAA_AAAA, 1'b0};
    tbl[10] = '{1'b1, 64'h8000_1FF8, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF, 64'd0, 1'b0};
    tbl[11] = '{1'b0, 64'h8000_1FFF, 64'd0, 8'h00, 64'hDEAD_BEEF_CAFE_F00D, 1'b0};
    tbl[12] = '{1'b0, 64'h0000_0000, 64'd0, 8'h00, 64'd0, 1'b1};
    for (int i = 0; i < 13; i++) begin
      do_access($sformatf("vec%0d", i), tbl[i].wen, tbl[i].addr, tbl[i].wdata, tbl[i].wmask,
                i % 3, tbl[i].exp_rdata, tbl[i].exp_err);
      model_access(tbl[i].wen, tbl[i].addr, tbl[i].wdata, tbl[i].wmask, e_rd, e_er);
    end

    // Back-pressure with a new request waiting throughout RESP.
    model_access(1'b0, 64'h8000_0010, 64'd0, 8'h00, e_rd, e_er);
    send_req(1'b0, 64'h8000_0010, 64'd0, 8'h00);
    wait_rsp(lat2);
    check("bp_lat", 64'(lat2), 64'(LAT));
    req_valid = 1'b1; req_wen = 1'b0; req_addr = 64'h8000_0000; req_wdata = 64'd0; req_wmask = 8'h00;
    finish_rsp(5, rd2, er2);
    check("bp_rdata", rd2, e_rd);
    check("bp_err", {63'd0, er2}, 64'd0);
    check("bp_ready_after_hs", {63'd0, req_ready}, 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("bp_accepted", {63'd0, req_ready}, 64'd0);
    wait_rsp(lat2);
    check("bp2_lat", 64'(lat2), 64'(LAT));
    model_access(1'b0, 64'h8000_0000, 64'd0, 8'h00, e_rd, e_er);
    finish_rsp(0, rd2, er2);
    check("bp2_rdata", rd2, e_rd);

    // Reset during WAIT: the write must never land.
    send_req(1'b1, 64'h8000_0000, 64'h5, 8'hFF);
    #2 rst = 1'b0;
    #1;
    check("rw_valid", {63'd0, rsp_valid}, 64'd0);
    check("rw_ready", {63'd0, req_ready}, 64'd1);
    check("rw_rdata", rsp_rdata, 64'd0);
    check("rw_err", {63'd0, rsp_err}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    model_access(1'b0, 64'h8000_0000, 64'd0, 8'h00, e_rd, e_er);
    do_access("rw_read", 1'b0, 64'h8000_0000, 64'd0, 8'h00, 0, e_rd, e_er);

    // Reset during RESP: the write has already landed.
    send_req(1'b1, 64'h8000_0000, 64'h77, 8'h01);
    wait_rsp(lat2);
    check("rr_lat", 64'(lat2), 64'(LAT));
    #2 rst = 1'b0;
    #1;
    check("rr_valid", {63'd0, rsp_valid}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    model_access(1'b1, 64'h8000_0000, 64'h77, 8'h01, e_rd, e_er);
    model_access(1'b0, 64'h8000_0000, 64'd0, 8'h00, e_rd, e_er);
    do_access("rr_read", 1'b0, 64'h8000_0000, 64'd0, 8'h00, 0, e_rd, e_er);

    // Randomized accesses over a small pool of words plus out-of-range hits.
    for (int w = 0; w < 16; w++) begin
      logic [63:0] d;
      d = {$urandom, $urandom};
      model_access(1'b1, BASE + 64'(w * 8), d, 8'hFF, e_rd, e_er);
      do_access("init", 1'b1, BASE + 64'(w * 8), d, 8'hFF, 0, e_rd, e_er);
    end
    for (int r = 0; r < 60; r++) begin
      logic        wen;
      logic [63:0] addr, d;
      logic [7:0]  m;
      wen = 1'($urandom % 2);
      if ($urandom % 10 == 0) begin
        if ($urandom % 2 == 0) addr = BASE + 64'(DEPTH * 8) + 64'(($urandom % 64) * 8);
        else                   addr = BASE - 64'((1 + $urandom % 8) * 8);
      end else begin
        addr = BASE + 64'(($urandom % 16) * 8) + 64'($urandom % 8);
      end
      d = {$urandom, $urandom};
      m = 8'($urandom);
      model_access(wen, addr, d, m, e_rd, e_er);
      do_access($sformatf("rnd%0d", r), wen, addr, d, m, int'($urandom % 3), e_rd, e_er);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
